// File: rtl/game_pkg.sv
// game_pkg: shared state encoding, datapath widths and extra-life step for game_sequencer
package game_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        HIT_FREEZE = 3'd2,
        GAME_OVER  = 3'd3,
        VICTORY    = 3'd4
    } game_state_t;

    localparam int SCORE_W         = 16;
    localparam int LIVES_W         = 4;
    localparam int ALIENS_W        = 8;
    localparam int EXTRA_LIFE_STEP = 500;

endpackage

// File: rtl/game_sequencer_frame_countdown.sv
// frame_countdown: loadable counter decremented once per frame tick, done while it holds 1
module frame_countdown #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         done
);

    logic [W-1:0] count;

    // load wins over tick; the count parks at zero instead of wrapping
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (tick && count != '0)
            count <= count - W'(1);
    end

    assign done = count == W'(1);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow FSM with per-frame collision commit, score, lives and wave tracking
// Optional feature: define GAME_SEQ_EXTRA_LIFE_EN to award a life each time score crosses a multiple of 500.
module game_sequencer
    import game_pkg::*;
#(
    parameter int NUM_ALIENS       = 24,
    parameter int START_LIVES      = 3,
    parameter int POINTS_PER_ALIEN = 10,
    parameter int FREEZE_FRAMES    = 60
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                startOfFrame,
    input  logic                startKey,
    input  logic                alienHitPulse,
    input  logic                playerHitPulse,
    output logic [2:0]          gameState,
    output logic                objectsEnable,
    output logic                newWavePulse,
    output logic                rocketKillPulse,
    output logic [SCORE_W-1:0]  score,
    output logic [LIVES_W-1:0]  lives,
    output logic [ALIENS_W-1:0] aliensLeft
);

    game_state_t         state, state_n;
    logic [SCORE_W-1:0]  score_n, score_sat;
    logic [SCORE_W:0]    score_sum;
    logic [LIVES_W-1:0]  lives_n, lives_base;
    logic [ALIENS_W-1:0] aliens_n, aliens_dec;
    logic                alien_pend, player_pend, alien_pend_n, player_pend_n;
    logic                wave_n, kill_n, freeze_load, freeze_done, start_key_d;

    frame_countdown #(.W(16)) u_freeze (
        .clk      (clk),
        .reset    (reset),
        .load     (freeze_load),
        .load_val (16'(FREEZE_FRAMES)),
        .tick     (state == HIT_FREEZE && startOfFrame),
        .done     (freeze_done)
    );

    assign score_sum  = {1'b0, score} + (SCORE_W+1)'(POINTS_PER_ALIEN);
    assign score_sat  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    assign aliens_dec = aliensLeft == '0 ? '0 : aliensLeft - ALIENS_W'(1);

`ifdef GAME_SEQ_EXTRA_LIFE_EN
    logic gained;
    assign gained     = alien_pend && (score_sat / SCORE_W'(EXTRA_LIFE_STEP)) != (score / SCORE_W'(EXTRA_LIFE_STEP));
    assign lives_base = (gained && lives != '1) ? lives + LIVES_W'(1) : lives;
`else
    assign lives_base = lives;
`endif

    // next-state and datapath: collisions latch per frame and are applied on the frame boundary
    always_comb begin
        state_n       = state;
        score_n       = score;
        lives_n       = lives;
        aliens_n      = aliensLeft;
        alien_pend_n  = 1'b0;
        player_pend_n = 1'b0;
        wave_n        = 1'b0;
        kill_n        = 1'b0;
        freeze_load   = 1'b0;
        case (state)
            IDLE: if (startKey) begin
                state_n  = PLAY;
                score_n  = '0;
                lives_n  = LIVES_W'(START_LIVES);
                aliens_n = ALIENS_W'(NUM_ALIENS);
                wave_n   = 1'b1;
            end
            PLAY: if (startOfFrame) begin
                alien_pend_n  = alienHitPulse;
                player_pend_n = playerHitPulse;
                score_n       = alien_pend ? score_sat : score;
                aliens_n      = alien_pend ? aliens_dec : aliensLeft;
                kill_n        = alien_pend;
                lives_n       = lives_base;
                if (alien_pend && aliens_dec == '0)
                    state_n = VICTORY;
                else if (player_pend) begin
                    lives_n     = lives_base - LIVES_W'(1);
                    state_n     = lives_n == '0 ? GAME_OVER : HIT_FREEZE;
                    freeze_load = lives_n != '0;
                end
            end else begin
                alien_pend_n  = alien_pend | alienHitPulse;
                player_pend_n = player_pend | playerHitPulse;
            end
            HIT_FREEZE: if (startOfFrame && freeze_done) begin
                state_n = PLAY;
                wave_n  = 1'b1;
            end
            GAME_OVER, VICTORY: state_n = (startKey && !start_key_d) ? IDLE : state;
            default: state_n = IDLE;
        endcase
    end

    // every output is a register so nothing passes combinationally from inputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            score           <= '0;
            lives           <= LIVES_W'(START_LIVES);
            aliensLeft      <= ALIENS_W'(NUM_ALIENS);
            alien_pend      <= 1'b0;
            player_pend     <= 1'b0;
            newWavePulse    <= 1'b0;
            rocketKillPulse <= 1'b0;
            objectsEnable   <= 1'b0;
            start_key_d     <= 1'b0;
        end else begin
            state           <= state_n;
            score           <= score_n;
            lives           <= lives_n;
            aliensLeft      <= aliens_n;
            alien_pend      <= alien_pend_n;
            player_pend     <= player_pend_n;
            newWavePulse    <= wave_n;
            rocketKillPulse <= kill_n;
            objectsEnable   <= state_n == PLAY;
            start_key_d     <= startKey;
        end
    end

    assign gameState = state;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed stimulus with a scoreboard of expected output snapshots per DUT event
module tb_game_sequencer;
    import game_pkg::*;

    typedef struct {
        string       tag;
        game_state_t st;
        int          sc;
        int          lv;
        int          al;
        logic        wave;
        logic        kill;
        logic        oe;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, startOfFrame, startKey, alienHitPulse, playerHitPulse;
    logic [2:0]  gameState;
    logic        objectsEnable, newWavePulse, rocketKillPulse;
    logic [15:0] score;
    logic [3:0]  lives;
    logic [7:0]  aliensLeft;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic        rst_q = 1'b0;
    logic [2:0]  prev_st = 3'd0;

    game_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .startKey        (startKey),
        .alienHitPulse   (alienHitPulse),
        .playerHitPulse  (playerHitPulse),
        .gameState       (gameState),
        .objectsEnable   (objectsEnable),
        .newWavePulse    (newWavePulse),
        .rocketKillPulse (rocketKillPulse),
        .score           (score),
        .lives           (lives),
        .aliensLeft      (aliensLeft)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= reset;

    task automatic chk(input string tag, input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s.%s: got %0d, expected %0d", tag, name, act, req);
        end
    endtask

    // monitor: a reset, a state change or any pulse is an event that must match the next expectation
    always @(negedge clk) begin
        if (rst_q || gameState !== prev_st || newWavePulse === 1'b1 || rocketKillPulse === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got state=%0d wave=%0b kill=%0b, expected no event", gameState, newWavePulse, rocketKillPulse);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk(e.tag, "state", int'(gameState), int'(e.st));
                chk(e.tag, "score", int'(score), e.sc);
                chk(e.tag, "lives", int'(lives), e.lv);
                chk(e.tag, "aliens", int'(aliensLeft), e.al);
                chk(e.tag, "wave", int'(newWavePulse), int'(e.wave));
                chk(e.tag, "kill", int'(rocketKillPulse), int'(e.kill));
                chk(e.tag, "enable", int'(objectsEnable), int'(e.oe));
            end
        end
        prev_st = gameState;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
    endtask

    task automatic push(input string tag, input game_state_t st, input int sc, input int lv, input int al,
                        input logic wave, input logic kill, input logic oe);
        exp_t e;
        e.tag = tag; e.st = st; e.sc = sc; e.lv = lv; e.al = al;
        e.wave = wave; e.kill = kill; e.oe = oe;
        sb.push_back(e);
    endtask

    task automatic start_game(input string tag);
        push(tag, PLAY, 0, 3, 24, 1, 0, 1);
        startKey = 1'b1;
        tick();
        startKey = 1'b0;
        tick();
    endtask

    task automatic player_hit(input string tag, input game_state_t st, input int sc, input int lv, input int al);
        playerHitPulse = 1'b1;
        tick();
        playerHitPulse = 1'b0;
        push(tag, st, sc, lv, al, 0, 0, 0);
        sof();
        tick();
    endtask

    task automatic ride_freeze(input string tag, input int sc, input int lv, input int al);
        for (int i = 0; i < 59; i++) begin
            alienHitPulse = 1'b1;
            sof();
            alienHitPulse = 1'b0;
        end
        push(tag, PLAY, sc, lv, al, 1, 0, 1);
        sof();
        tick();
        sof();
        tick();
    endtask

    initial begin
        reset = 1'b1; startOfFrame = 1'b0; startKey = 1'b0; alienHitPulse = 1'b0; playerHitPulse = 1'b0;
        push("reset", IDLE, 0, 3, 24, 0, 0, 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        start_game("start");
        tick();
        for (int i = 0; i < 5; i++) begin
            alienHitPulse = 1'b1;
            tick();
        end
        alienHitPulse = 1'b0;
        push("five_hits", PLAY, 10, 3, 23, 0, 1, 1);
        sof();
        tick();
        tick();
        alienHitPulse = 1'b1;
        sof();
        alienHitPulse = 1'b0;
        tick();
        push("carried_hit", PLAY, 20, 3, 22, 0, 1, 1);
        sof();
        tick();
        player_hit("freeze", HIT_FREEZE, 20, 2, 22);
        ride_freeze("unfreeze", 20, 2, 22);
        for (int i = 1; i <= 21; i++) begin
            alienHitPulse = 1'b1;
            tick();
            alienHitPulse = 1'b0;
            push("kill_run", PLAY, 20 + 10 * i, 2, 22 - i, 0, 1, 1);
            sof();
        end
        tick();
        alienHitPulse = 1'b1;
        playerHitPulse = 1'b1;
        tick();
        alienHitPulse = 1'b0;
        playerHitPulse = 1'b0;
        push("victory", VICTORY, 240, 2, 0, 0, 1, 0);
        sof();
        tick();
        tick();
        push("victory_exit", IDLE, 240, 2, 0, 0, 0, 0);
        startKey = 1'b1;
        tick();
        startKey = 1'b0;
        tick();
        tick();
        start_game("restart");
        player_hit("hit1", HIT_FREEZE, 0, 2, 24);
        ride_freeze("thaw1", 0, 2, 24);
        player_hit("hit2", HIT_FREEZE, 0, 1, 24);
        ride_freeze("thaw2", 0, 1, 24);
        startKey = 1'b1;
        player_hit("game_over", GAME_OVER, 0, 0, 24);
        for (int i = 0; i < 5; i++) tick();
        startKey = 1'b0;
        tick();
        tick();
        push("over_exit", IDLE, 0, 0, 24, 0, 0, 0);
        startKey = 1'b1;
        tick();
        startKey = 1'b0;
        tick();
        tick();
        start_game("third");
        player_hit("hit3", HIT_FREEZE, 0, 2, 24);
        sof();
        sof();
        push("reset_freeze", IDLE, 0, 3, 24, 0, 0, 0);
        reset = 1'b1;
        startOfFrame = 1'b1;
        tick();
        reset = 1'b0;
        startOfFrame = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("end", "pending", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
